// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmit arbiter slice:
//     - one-hot state encodings of the arbiter sequencer
//     - default WORD_SIZE / TIMEOUT_CYCLES values
//     - wrap_inc(): modulo-n increment used for the round-robin walk
//   No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int WORD_SIZE_DEFAULT      = 8;
    localparam int TIMEOUT_CYCLES_DEFAULT = 4096;

    // One state bit per state; IDLE is bit 0, DONE is bit 5.
    typedef enum logic [5:0] {
        ST_IDLE      = 6'b000001,
        ST_LOAD_DR   = 6'b000010,
        ST_LOAD_SR   = 6'b000100,
        ST_START     = 6'b001000,
        ST_WAIT_DONE = 6'b010000,
        ST_DONE      = 6'b100000
    } state_e;

    // Next index in a ring of n entries (n-1 wraps back to 0).
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_xmt_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_xmt_arbiter_if
//   Bundle of the requester-side and transmitter-side signals of the arbiter.
//   Signals:
//     req / data_in / ack              requester handshake (N_REQ lanes)
//     grant                            one-hot current owner
//     Data_Bus                         latched byte for the transmit data reg
//     Load_XMT_datareg/Byte_ready/T_byte  control-unit handshake pulses
//     xmt_clear                        end-of-frame pulse from the control unit
//     busy / timeout_err               status
//   Modports:
//     master - the arbiter (drives grant, ack, Data_Bus, pulses, status)
//     slave  - the environment (drives req, data_in, xmt_clear)
//   N_REQ / WORD_SIZE must match the arbiter instance they connect to.
// -----------------------------------------------------------------------------
interface uart_xmt_arbiter_if
    import uart_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WORD_SIZE = WORD_SIZE_DEFAULT
) ();

    logic [N_REQ-1:0]           req;
    logic [N_REQ*WORD_SIZE-1:0] data_in;
    logic [N_REQ-1:0]           ack;
    logic [N_REQ-1:0]           grant;
    logic [WORD_SIZE-1:0]       Data_Bus;
    logic                       Load_XMT_datareg;
    logic                       Byte_ready;
    logic                       T_byte;
    logic                       xmt_clear;
    logic                       busy;
    logic                       timeout_err;

    modport master (
        input  req, data_in, xmt_clear,
        output ack, grant, Data_Bus, Load_XMT_datareg, Byte_ready, T_byte,
               busy, timeout_err
    );

    modport slave (
        output req, data_in, xmt_clear,
        input  ack, grant, Data_Bus, Load_XMT_datareg, Byte_ready, T_byte,
               busy, timeout_err
    );

endinterface

// File: rtl/uart_rr_pick.sv
// -----------------------------------------------------------------------------
// uart_rr_pick
//   Combinational round-robin picker. Starting at i_ptr and walking upward
//   with wraparound, returns the first requester whose i_req bit is set.
//   Ports:
//     i_req     N_REQ   request vector
//     i_ptr     IDX_W   index to start the search from (< N_REQ)
//     o_idx     IDX_W   winner index (0 when none)
//     o_onehot  N_REQ   winner as a one-hot vector (0 when none)
//     o_valid   1       at least one request present
// -----------------------------------------------------------------------------
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_idx,
    output logic [N_REQ-1:0] o_onehot,
    output logic             o_valid
);

    logic [IDX_W-1:0] w_cur;

    always_comb begin
        // NOTE: every signal driven here gets a default first; a path that
        // leaves one unassigned would otherwise infer a latch.
        o_valid  = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        w_cur    = i_ptr;
        // Visit every slot once, beginning at the pointer; the first hit wins.
        for (int i = 0; i < N_REQ; i++) begin
            if (!o_valid && i_req[w_cur]) begin
                o_valid         = 1'b1;
                o_idx           = w_cur;
                o_onehot[w_cur] = 1'b1;
            end
            w_cur = IDX_W'(wrap_inc(int'(w_cur), N_REQ));
        end
    end

endmodule

// File: rtl/uart_xmt_arbiter.sv
// -----------------------------------------------------------------------------
// uart_xmt_arbiter
//   Shares one UART transmitter between N_REQ byte requesters. A round-robin
//   winner's byte is latched onto Data_Bus, then the transmit control unit is
//   walked through Load_XMT_datareg -> Byte_ready -> T_byte (one cycle each).
//   The arbiter then waits for xmt_clear (end of frame), pulses ack to the
//   owner and releases the transmitter. A frame that never clears is aborted
//   after TIMEOUT_CYCLES cycles with ack and timeout_err pulsed together.
//   Ports:
//     Clock   1   system clock, rising edge
//     rst     1   synchronous, active-high reset
//     io_bus  uart_xmt_arbiter_if.master (see interface header)
//   All outputs come straight from registers.
// -----------------------------------------------------------------------------
module uart_xmt_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int WORD_SIZE      = WORD_SIZE_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic               Clock,
    input  logic               rst,
    uart_xmt_arbiter_if.master io_bus
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    // State and registered outputs
    state_e               r_state;
    logic [N_REQ-1:0]     r_grant;
    logic [WORD_SIZE-1:0] r_data_bus;
    logic                 r_load;
    logic                 r_byte_ready;
    logic                 r_t_byte;
    logic [N_REQ-1:0]     r_ack;
    logic                 r_timeout_err;
    logic                 r_busy;
    // Bookkeeping
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     r_winner;

    // Next-state values
    state_e               w_state_nxt;
    logic [N_REQ-1:0]     w_grant_nxt;
    logic [WORD_SIZE-1:0] w_data_bus_nxt;
    logic                 w_load_nxt;
    logic                 w_byte_ready_nxt;
    logic                 w_t_byte_nxt;
    logic [N_REQ-1:0]     w_ack_nxt;
    logic                 w_timeout_err_nxt;
    logic                 w_busy_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [IDX_W-1:0]     w_ptr_nxt;
    logic [IDX_W-1:0]     w_winner_nxt;

    // Picker results and timeout detect
    logic                 w_pick_valid;
    logic [IDX_W-1:0]     w_pick_idx;
    logic [N_REQ-1:0]     w_pick_onehot;
    logic                 w_cnt_expired;

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req    (io_bus.req),
        .i_ptr    (r_ptr),
        .o_idx    (w_pick_idx),
        .o_onehot (w_pick_onehot),
        .o_valid  (w_pick_valid)
    );

    // r_cnt holds the number of WAIT_DONE cycles already spent, so the
    // TIMEOUT_CYCLES-th WAIT_DONE cycle is the one that sees TIMEOUT_CYCLES-1.
    assign w_cnt_expired = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // -------------------------------------------------------------------------
    // State register (plus registered outputs and bookkeeping)
    // -------------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples its pre-edge inputs and all of them update together.
        if (rst) begin
            // NOTE: datapath registers (Data_Bus, pointer, counter) are reset
            // as well; a reset mid-frame must leave no stale owner or ack.
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_data_bus    <= '0;
            r_load        <= 1'b0;
            r_byte_ready  <= 1'b0;
            r_t_byte      <= 1'b0;
            r_ack         <= '0;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b0;
            r_cnt         <= '0;
            r_ptr         <= '0;
            r_winner      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_data_bus    <= w_data_bus_nxt;
            r_load        <= w_load_nxt;
            r_byte_ready  <= w_byte_ready_nxt;
            r_t_byte      <= w_t_byte_nxt;
            r_ack         <= w_ack_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_busy        <= w_busy_nxt;
            r_cnt         <= w_cnt_nxt;
            r_ptr         <= w_ptr_nxt;
            r_winner      <= w_winner_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (w_pick_valid) w_state_nxt = ST_LOAD_DR;
            ST_LOAD_DR:   w_state_nxt = ST_LOAD_SR;
            ST_LOAD_SR:   w_state_nxt = ST_START;
            ST_START:     w_state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: if (io_bus.xmt_clear || w_cnt_expired) w_state_nxt = ST_DONE;
            ST_DONE:      w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: values the output registers take at the next edge
    // -------------------------------------------------------------------------
    always_comb begin
        // Ownership, latched byte, pointer and counter hold by default;
        // handshake pulses and ack/timeout_err default low so each lasts
        // exactly one cycle.
        w_grant_nxt       = r_grant;
        w_data_bus_nxt    = r_data_bus;
        w_winner_nxt      = r_winner;
        w_ptr_nxt         = r_ptr;
        w_cnt_nxt         = r_cnt;
        w_load_nxt        = 1'b0;
        w_byte_ready_nxt  = 1'b0;
        w_t_byte_nxt      = 1'b0;
        w_ack_nxt         = '0;
        w_timeout_err_nxt = 1'b0;
        w_busy_nxt        = (w_state_nxt != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                // data_in is captured only here; later changes are ignored.
                if (w_pick_valid) begin
                    w_grant_nxt    = w_pick_onehot;
                    w_winner_nxt   = w_pick_idx;
                    w_data_bus_nxt = io_bus.data_in[int'(w_pick_idx)*WORD_SIZE +: WORD_SIZE];
                    w_load_nxt     = 1'b1;
                end
            end
            ST_LOAD_DR: w_byte_ready_nxt = 1'b1;
            ST_LOAD_SR: w_t_byte_nxt     = 1'b1;
            ST_START:   w_cnt_nxt        = '0;
            ST_WAIT_DONE: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                // A clear arriving on the last allowed cycle still counts as
                // a normal completion.
                if (io_bus.xmt_clear) begin
                    w_ack_nxt = r_grant;
                end else if (w_cnt_expired) begin
                    w_ack_nxt         = r_grant;
                    w_timeout_err_nxt = 1'b1;
                end
            end
            ST_DONE: begin
                w_grant_nxt = '0;
                w_ptr_nxt   = IDX_W'(wrap_inc(int'(r_winner), N_REQ));
            end
            default: ;
        endcase
    end

    assign io_bus.grant            = r_grant;
    assign io_bus.Data_Bus         = r_data_bus;
    assign io_bus.Load_XMT_datareg = r_load;
    assign io_bus.Byte_ready       = r_byte_ready;
    assign io_bus.T_byte           = r_t_byte;
    assign io_bus.ack              = r_ack;
    assign io_bus.timeout_err      = r_timeout_err;
    assign io_bus.busy             = r_busy;

endmodule

// File: tb/tb_uart_xmt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_xmt_arbiter
//   Directed bench for uart_xmt_arbiter. Stimulus pushes the expected grant /
//   byte / cycle of each Load_XMT_datareg pulse and the expected ack /
//   timeout_err / cycle of each completion into queues; a negedge monitor
//   pops and compares whenever the DUT presents one of those pulses, and also
//   tracks Byte_ready / T_byte sequencing, Data_Bus stability and the
//   grant / ack invariants. "cyc" counts rising edges; an output produced by
//   edge k is seen by the monitor while cyc == k.
// -----------------------------------------------------------------------------
module tb_uart_xmt_arbiter;

    localparam int N_REQ     = 4;
    localparam int WORD_SIZE = 8;
    localparam int TIMEOUT   = 128;

    typedef struct {
        logic [N_REQ-1:0]     grant;
        logic [WORD_SIZE-1:0] data;
        int                   cyc;
    } load_exp_t;

    typedef struct {
        logic [N_REQ-1:0] ack;
        logic             terr;
        int               cyc;
    } ack_exp_t;

    logic Clock = 1'b0;
    logic rst   = 1'b1;

    uart_xmt_arbiter_if #(.N_REQ(N_REQ), .WORD_SIZE(WORD_SIZE)) bus ();

    uart_xmt_arbiter #(
        .N_REQ          (N_REQ),
        .WORD_SIZE      (WORD_SIZE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .Clock  (Clock),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 Clock = ~Clock;

    int        n_cmp = 0;
    int        n_fail = 0;
    int        cyc = 0;
    logic      rst_sampled = 1'b0;
    int        ack_cnt [N_REQ];
    load_exp_t load_q [$];
    ack_exp_t  ack_q [$];
    logic [WORD_SIZE-1:0] src [N_REQ];

    always @(posedge Clock) begin
        cyc         <= cyc + 1;
        rst_sampled <= rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_event(input string name, input string what);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: %s (cyc %0d)", name, what, cyc);
    endtask

    // ---------------------------------------------------------------- monitor
    load_exp_t            m_le;
    ack_exp_t             m_ae;
    int                   last_load = -100;
    logic [WORD_SIZE-1:0] cur_bus = '0;

    always @(negedge Clock) begin
        if (rst_sampled) begin
            cur_bus   = '0;
            last_load = -100;
        end
        check("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
        check("ack_subset_grant", 32'(bus.ack & ~bus.grant), 32'd0);

        if (bus.Load_XMT_datareg) begin
            if (load_q.size() == 0) begin
                fail_event("load_unexpected", "Load_XMT_datareg pulsed, required no pulse");
            end else begin
                m_le = load_q.pop_front();
                check("load_grant", 32'(bus.grant), 32'(m_le.grant));
                check("load_data", 32'(bus.Data_Bus), 32'(m_le.data));
                check("load_cycle", cyc, m_le.cyc);
                cur_bus   = m_le.data;
                last_load = cyc;
            end
        end
        check("data_bus_hold", 32'(bus.Data_Bus), 32'(cur_bus));
        if (bus.Byte_ready || cyc == last_load + 1)
            check("byte_ready", 32'(bus.Byte_ready), 32'(cyc == last_load + 1));
        if (bus.T_byte || cyc == last_load + 2)
            check("t_byte", 32'(bus.T_byte), 32'(cyc == last_load + 2));

        if (|bus.ack || bus.timeout_err) begin
            if (ack_q.size() == 0) begin
                fail_event("ack_unexpected", "ack/timeout_err pulsed, required no pulse");
            end else begin
                m_ae = ack_q.pop_front();
                check("ack_value", 32'(bus.ack), 32'(m_ae.ack));
                check("ack_timeout_err", 32'(bus.timeout_err), 32'(m_ae.terr));
                check("ack_cycle", cyc, m_ae.cyc);
            end
            for (int i = 0; i < N_REQ; i++) ack_cnt[i] += int'(bus.ack[i]);
        end
    end

    // -------------------------------------------------------------- stimulus
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive_data();
        for (int i = 0; i < N_REQ; i++) bus.data_in[i*WORD_SIZE +: WORD_SIZE] = src[i];
    endtask

    task automatic expect_load(input logic [N_REQ-1:0] g, input logic [WORD_SIZE-1:0] d,
                               input int at_cyc);
        load_exp_t e;
        e.grant = g;
        e.data  = d;
        e.cyc   = at_cyc;
        load_q.push_back(e);
    endtask

    task automatic wait_tbyte(output int t);
        int k;
        k = 0;
        t = -1;
        while (k < 40 && t < 0) begin
            if (bus.T_byte) t = cyc;
            else begin
                step();
                k++;
            end
        end
        if (t < 0) begin
            fail_event("t_byte_wait", "no T_byte within 40 cycles, required a pulse");
            t = cyc;
        end
    endtask

    // Waits for T_byte, then either pulses xmt_clear after clear_delay cycles
    // or (clear_delay < 0) lets the frame time out. Returns at the ack cycle.
    task automatic finish_frame(input logic [N_REQ-1:0] g, input int clear_delay,
                                output int ack_cyc);
        int       t;
        ack_exp_t e;
        wait_tbyte(t);
        e.ack = g;
        if (clear_delay < 0) begin
            e.terr = 1'b1;
            e.cyc  = t + 1 + TIMEOUT;
            ack_q.push_back(e);
            while (cyc < t + 1 + TIMEOUT) step();
        end else begin
            repeat (clear_delay) step();
            bus.xmt_clear = 1'b1;
            e.terr = 1'b0;
            e.cyc  = cyc + 1;
            ack_q.push_back(e);
            step();
            bus.xmt_clear = 1'b0;
        end
        ack_cyc = cyc;
    endtask

    int a;
    int c;
    int nxt;
    int snap [N_REQ];

    initial begin
        src = '{8'h11, 8'h22, 8'hA5, 8'h44};
        bus.req       = '0;
        bus.xmt_clear = 1'b0;
        drive_data();
        rst = 1'b1;
        repeat (3) step();

        // Reset state
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_data_bus", 32'(bus.Data_Bus), 32'd0);
        check("rst_load", 32'(bus.Load_XMT_datareg), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
        rst = 1'b0;

        // xmt_clear while IDLE must be ignored (any ack is unexpected)
        bus.xmt_clear = 1'b1;
        step();
        bus.xmt_clear = 1'b0;
        step();

        // 1. Single request from requester 2
        bus.req = 4'b0100;
        c = cyc;
        expect_load(4'b0100, 8'hA5, c + 1);
        finish_frame(4'b0100, 90, a);
        bus.req = '0;
        check("t1_busy_in_done", 32'(bus.busy), 32'd1);
        step();

        // 6. Data stability: byte changes after grant, req dropped in LOAD_SR,
        //    stray xmt_clear while in LOAD_DR
        src[3] = 8'h3C;
        drive_data();
        bus.req = 4'b1000;
        c = cyc;
        expect_load(4'b1000, 8'h3C, c + 1);
        step();
        src[3] = 8'hFF;
        src[0] = 8'hEE;
        drive_data();
        bus.xmt_clear = 1'b1;
        step();
        bus.xmt_clear = 1'b0;
        bus.req = '0;
        finish_frame(4'b1000, 30, a);
        src[3] = 8'h44;
        src[0] = 8'h11;
        drive_data();
        step();

        // 2. Contention: all four request; strict rotation from pointer 0
        for (int i = 0; i < N_REQ; i++) snap[i] = ack_cnt[i];
        bus.req = 4'b1111;
        nxt = cyc + 1;
        for (int k = 0; k < 8; k++) begin
            expect_load(4'(1 << (k % N_REQ)), src[k % N_REQ], nxt);
            finish_frame(4'(1 << (k % N_REQ)), 20, a);
            nxt = a + 2;
        end
        bus.req = '0;
        step();
        for (int i = 0; i < N_REQ; i++) check("ack_count_fair", ack_cnt[i] - snap[i], 2);

        // 3. Timeout: requester 0, xmt_clear never comes
        bus.req = 4'b0001;
        expect_load(4'b0001, 8'h11, cyc + 1);
        finish_frame(4'b0001, -1, a);
        bus.req = '0;
        step();
        step();
        check("t3_busy_low", 32'(bus.busy), 32'd0);

        // 4. xmt_clear on the final timeout cycle: clear wins, no timeout_err
        bus.req = 4'b0001;
        expect_load(4'b0001, 8'h11, cyc + 1);
        finish_frame(4'b0001, TIMEOUT, a);
        bus.req = '0;
        step();

        // 5. Reset during WAIT_DONE (pointer is 1 at this point)
        bus.req = 4'b0010;
        expect_load(4'b0010, 8'h22, cyc + 1);
        wait_tbyte(c);
        repeat (10) step();
        rst = 1'b1;
        step();
        check("mid_rst_grant", 32'(bus.grant), 32'd0);
        check("mid_rst_ack", 32'(bus.ack), 32'd0);
        check("mid_rst_data_bus", 32'(bus.Data_Bus), 32'd0);
        check("mid_rst_pulses", 32'({bus.Load_XMT_datareg, bus.Byte_ready, bus.T_byte}), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_timeout_err", 32'(bus.timeout_err), 32'd0);
        rst = 1'b0;
        bus.req = 4'b0011;
        expect_load(4'b0001, 8'h11, cyc + 1);
        finish_frame(4'b0001, 15, a);
        bus.req = 4'b0010;
        expect_load(4'b0010, 8'h22, a + 2);
        finish_frame(4'b0010, 15, a);
        bus.req = '0;
        repeat (4) step();

        check("load_queue_drained", load_q.size(), 0);
        check("ack_queue_drained", ack_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete within 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/uart_xmt_arbiter.md
Name: uart_xmt_arbiter

Overview:
- Shares one UART transmitter (datapath plus its transmit control unit) between N_REQ byte requesters.
- Round-robin arbitration; latches the winner's byte onto Data_Bus.
- Sequences the control unit's handshake inputs: Load_XMT_datareg, then Byte_ready, then T_byte.
- Waits for end-of-frame (the control unit's clear pulse), acknowledges the requester, and recovers from a stuck transmitter with a timeout.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WORD_SIZE, 8, data bits per byte.
- TIMEOUT_CYCLES, 4096, max cycles in WAIT_DONE before aborting; counter width clog2(TIMEOUT_CYCLES+1).

Ports:
- Clock  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-requester byte request; level, held until ack.
- data_in  input  N_REQ*WORD_SIZE  requester i byte at [i*WORD_SIZE +: WORD_SIZE].
- ack  output  N_REQ  one-cycle completion pulse to the granted requester.
- grant  output  N_REQ  one-hot current owner; zero when idle.
- Data_Bus  output  WORD_SIZE  latched byte to the transmitter data register.
- Load_XMT_datareg  output  1  one-cycle pulse to the control unit.
- Byte_ready  output  1  one-cycle pulse to the control unit.
- T_byte  output  1  one-cycle pulse to the control unit.
- xmt_clear  input  1  control unit clear pulse (last bit sent).
- busy  output  1  high in every state except IDLE.
- timeout_err  output  1  one-cycle pulse, coincident with ack, on timeout abort.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - All outputs 0; Data_Bus = 0.
  - State IDLE; round-robin pointer = 0; timeout counter = 0.
  - Reset mid-transaction aborts silently: no ack.
- All outputs are registered.
- States, one-hot encoded: IDLE, LOAD_DR, LOAD_SR, START, WAIT_DONE, DONE.
- IDLE:
  - If |req: pick winner w, searching upward from pointer with wraparound.
  - grant <= onehot(w); Data_Bus <= data_in[w]; Load_XMT_datareg <= 1; go LOAD_DR.
  - If no req: stay in IDLE.
- LOAD_DR: Load_XMT_datareg <= 0; Byte_ready <= 1; go LOAD_SR.
- LOAD_SR: Byte_ready <= 0; T_byte <= 1; go START.
- START: T_byte <= 0; clear timeout counter; go WAIT_DONE.
- WAIT_DONE:
  - Counter increments each cycle.
  - xmt_clear=1: ack <= grant; go DONE.
  - Else, counter == TIMEOUT_CYCLES-1: ack <= grant; timeout_err <= 1; go DONE.
- DONE:
  - ack and timeout_err return to 0.
  - grant <= 0; pointer <= (w+1) mod N_REQ; go IDLE.
- Latency:
  - req high in IDLE to Load_XMT_datareg high: 1 edge.
  - Load_XMT_datareg, Byte_ready and T_byte each high exactly 1 cycle, in consecutive cycles.
  - xmt_clear to ack: 1 edge.
  - ack to next possible Load_XMT_datareg: 2 edges.
- Handshake rules:
  - req is sampled only in IDLE.
  - data_in is captured only at grant; later changes are ignored.
  - Requester dropping req mid-transaction: frame still completes and ack still pulses.
  - Requester keeping req high after ack: re-arbitrated fairly in the next IDLE.
- Boundary conditions:
  - xmt_clear outside WAIT_DONE: ignored.
  - xmt_clear and timeout expiry in the same cycle: clear wins; no timeout_err.
  - All requesters active: strict rotation 0,1,2,3,0,...
  - Pointer wraps at N_REQ-1 to 0.
- Invariants: grant is one-hot or zero; ack is a subset of grant.

Decomposition:
- Shared package uart_pkg holds:
  - State one-hot encodings (6-bit): IDLE=000001 ... DONE=100000.
  - Defaults for WORD_SIZE and TIMEOUT_CYCLES.
- Sub-module uart_rr_pick: combinational round-robin picker.
  - Inputs: req, pointer. Outputs: winner index, one-hot winner, valid.
  - Instantiated once in the IDLE decision path.

Test Plan:
1. Single request: req=0100, data_in[2]=8'hA5.
   - Load_XMT_datareg, Byte_ready, T_byte pulse on edges 1, 2, 3 with Data_Bus=8'hA5 and grant=0100.
   - xmt_clear pulsed 90 cycles later gives ack=0100 for exactly 1 cycle.
2. Contention: req=1111 held, each xmt_clear returned 20 cycles after T_byte.
   - Grant order 0001, 0010, 0100, 1000, 0001.
   - ack count per requester equal after 8 frames.
3. Timeout: req=0001, xmt_clear never asserted.
   - ack=0001 and timeout_err=1 together exactly TIMEOUT_CYCLES cycles after entering WAIT_DONE.
   - busy=0 two edges later.
4. Simultaneous: xmt_clear on the final timeout cycle gives ack with timeout_err=0.
5. Mid-operation reset: rst=1 during WAIT_DONE.
   - Next edge: all outputs 0 and state IDLE.
   - Subsequent req=0011 grants requester 0 first.
6. Data stability: data_in changed after grant gives Data_Bus unchanged until the next grant.
   - req dropped during LOAD_SR still gives ack after xmt_clear.
